mcdt_formatter: RTL and testbench

Downstream stage of `mcdt`. Consumes the arbitrated `mcdt_data`/`mcdt_val`/`mcdt_id` word stream and keeps one FIFO per channel. Packs buffered words into fixed-length packets and hands them to a packet receiver over a request/grant handshake. The upstream stream has no backpressure, so the formatter accepts a word on every cycle in which the word is valid.

---
 rtl/mcdt_fmt_pkg.sv | 24 ++
 rtl/mcdt_fmt_fifo.sv | 52 +++++
 rtl/mcdt_formatter.sv | 151 +++++++++++++++
 tb/tb_mcdt_formatter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcdt_fmt_pkg.sv
// Shared constants and types for the mcdt packet formatter.
// The channel ring helper keeps the round-robin search in one place.
package mcdt_fmt_pkg;

   localparam int unsigned CH_NUM  = 3;
   localparam int unsigned CH_ID_W = 2;
   localparam int unsigned LEN_W   = 5;

   typedef enum logic [1:0] {IDLE, REQ, SEND} fmt_state_e;

   typedef struct packed {
      logic [CH_ID_W-1:0] chid;
      logic [LEN_W-1:0]   length;
   } fmt_pkt_t;

   // Channel reached by stepping `off` places round the ring from `ch`.
   function automatic logic [CH_ID_W-1:0] ch_step(input logic [CH_ID_W-1:0] ch,
                                                  input int unsigned        off);
      int unsigned sum;
      sum = (32'(ch) + off) % CH_NUM;
      return CH_ID_W'(sum);
   endfunction

endpackage

// File: rtl/mcdt_fmt_fifo.sv
// Per-channel synchronous FIFO with combinational head read.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module mcdt_fmt_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 32
) (
   input  logic                   clk_i,
   input  logic                   rstn_i,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic [WIDTH-1:0]       data_i,
   output logic [WIDTH-1:0]       data_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int unsigned AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   // A pop frees the slot in the same cycle, so a full FIFO may still take a push.
   assign w_pop  = pop_i && (r_count != '0);
   assign w_push = push_i && ((r_count != FULL_CNT) || w_pop);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wptr] <= data_i;
   end

   assign data_o  = r_mem[r_rptr];
   assign full_o  = (r_count == FULL_CNT);
   assign empty_o = (r_count == '0);
   assign count_o = r_count;

endmodule

// File: rtl/mcdt_formatter.sv
// Buffers the arbitrated mcdt word stream per channel and emits fixed-length
// packets over a request/grant handshake, serving channels round-robin.
module mcdt_formatter
   import mcdt_fmt_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned PKT_LEN    = 4
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic [31:0] mcdt_data_i,
   input  logic        mcdt_val_i,
   input  logic [1:0]  mcdt_id_i,
   output logic        fmt_req_o,
   input  logic        fmt_grant_i,
   output logic [1:0]  fmt_chid_o,
   output logic [4:0]  fmt_length_o,
   output logic        fmt_start_o,
   output logic        fmt_end_o,
   output logic [31:0] fmt_data_o,
   output logic [2:0]  fmt_ovf_o
);
   localparam int unsigned       CNT_W     = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned       BEAT_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

   fmt_state_e         r_state, w_state_nxt;
   fmt_pkt_t           r_pkt, w_pkt_nxt;
   logic [CH_ID_W-1:0] r_rr_ptr, w_rr_nxt;
   logic [BEAT_W-1:0]  r_beat, w_beat_nxt;
   logic               r_start, w_start_nxt;
   logic               r_end, w_end_nxt;
   logic [31:0]        r_data, w_data_nxt;
   logic [CH_NUM-1:0]  r_ovf, w_ovf_nxt;

   logic [CH_NUM-1:0]  w_push, w_pop, w_full, w_empty, w_elig;
   logic [31:0]        w_rdata [CH_NUM];
   logic [CNT_W-1:0]   w_count [CH_NUM];
   logic [31:0]        w_head;
   logic               w_sel_found;
   logic [CH_ID_W-1:0] w_sel_ch;

   // Id 3 matches no channel, so those words vanish without touching any flag.
   for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
      assign w_push[g] = mcdt_val_i && (mcdt_id_i == CH_ID_W'(g));
      assign w_elig[g] = (w_count[g] >= CNT_W'(PKT_LEN));

      mcdt_fmt_fifo #(
         .DEPTH (FIFO_DEPTH),
         .WIDTH (32)
      ) u_fifo (
         .clk_i   (clk_i),
         .rstn_i  (rstn_i),
         .push_i  (w_push[g]),
         .pop_i   (w_pop[g]),
         .data_i  (mcdt_data_i),
         .data_o  (w_rdata[g]),
         .full_o  (w_full[g]),
         .empty_o (w_empty[g]),
         .count_o (w_count[g])
      );
   end

   assign w_head    = w_rdata[r_pkt.chid];
   assign w_ovf_nxt = r_ovf | (w_push & w_full & ~w_pop);

   always_comb begin
      w_state_nxt = r_state;
      w_pkt_nxt   = r_pkt;
      w_rr_nxt    = r_rr_ptr;
      w_beat_nxt  = r_beat;
      w_start_nxt = 1'b0;
      w_end_nxt   = 1'b0;
      w_data_nxt  = '0;
      w_pop       = '0;
      w_sel_found = 1'b0;
      w_sel_ch    = r_rr_ptr;

      for (int unsigned k = 1; k <= CH_NUM; k++) begin
         if (!w_sel_found && w_elig[ch_step(r_rr_ptr, k)]) begin
            w_sel_found = 1'b1;
            w_sel_ch    = ch_step(r_rr_ptr, k);
         end
      end

      // Beat outputs are loaded on the edge that pops the word, so beat 0
      // appears the cycle right after the grant is sampled.
      unique case (r_state)
         IDLE: begin
            if (w_sel_found) begin
               w_state_nxt      = REQ;
               w_pkt_nxt.chid   = w_sel_ch;
               w_pkt_nxt.length = LEN_W'(PKT_LEN);
            end
         end
         REQ: begin
            if (fmt_grant_i) begin
               w_state_nxt          = SEND;
               w_beat_nxt           = '0;
               w_pop[r_pkt.chid]    = !w_empty[r_pkt.chid];
               w_data_nxt           = w_head;
               w_start_nxt          = 1'b1;
               w_end_nxt            = (LAST_BEAT == '0);
            end
         end
         SEND: begin
            if (r_beat == LAST_BEAT) begin
               w_state_nxt = IDLE;
               w_rr_nxt    = r_pkt.chid;
            end else begin
               w_beat_nxt        = r_beat + 1'b1;
               w_pop[r_pkt.chid] = !w_empty[r_pkt.chid];
               w_data_nxt        = w_head;
               w_end_nxt         = ((r_beat + 1'b1) == LAST_BEAT);
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state  <= IDLE;
         r_pkt    <= '0;
         r_rr_ptr <= CH_ID_W'(2);
         r_beat   <= '0;
         r_start  <= 1'b0;
         r_end    <= 1'b0;
         r_data   <= '0;
         r_ovf    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_pkt    <= w_pkt_nxt;
         r_rr_ptr <= w_rr_nxt;
         r_beat   <= w_beat_nxt;
         r_start  <= w_start_nxt;
         r_end    <= w_end_nxt;
         r_data   <= w_data_nxt;
         r_ovf    <= w_ovf_nxt;
      end
   end

   assign fmt_req_o    = (r_state == REQ);
   assign fmt_chid_o   = r_pkt.chid;
   assign fmt_length_o = r_pkt.length;
   assign fmt_start_o  = r_start;
   assign fmt_end_o    = r_end;
   assign fmt_data_o   = r_data;
   assign fmt_ovf_o    = r_ovf;

endmodule

// File: tb/tb_mcdt_formatter.sv
// Directed bench for mcdt_formatter: a cycle table for one packet, then
// hand-written sequences for arbitration, stalls, overflow, reset and bursts.
module tb_mcdt_formatter;

   localparam int DEPTH   = 16;
   localparam int PKT_LEN = 4;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] mcdt_data = '0;
   logic        mcdt_val = 1'b0;
   logic [1:0]  mcdt_id = '0;
   logic        fmt_grant = 1'b0;
   logic        fmt_req_o;
   logic [1:0]  fmt_chid_o;
   logic [4:0]  fmt_length_o;
   logic        fmt_start_o;
   logic        fmt_end_o;
   logic [31:0] fmt_data_o;
   logic [2:0]  fmt_ovf_o;

   int tests = 0;
   int fails = 0;

   logic [31:0] exp_q [3][$];
   logic [1:0]  pkt_order [$];
   int          beats_seen = 0;
   int          mon_idx = 0;
   int          mon_ch;
   logic [31:0] mon_exp;

   typedef struct packed {
      logic        val;
      logic [1:0]  id;
      logic [31:0] data;
      logic        grant;
      logic        req;
      logic [1:0]  chid;
      logic [4:0]  len;
      logic        start;
      logic        fin;
      logic [31:0] dout;
   } vec_t;

   vec_t vecs [12];

   mcdt_formatter #(
      .FIFO_DEPTH (DEPTH),
      .PKT_LEN    (PKT_LEN)
   ) dut (
      .clk_i        (clk),
      .rstn_i       (rstn),
      .mcdt_data_i  (mcdt_data),
      .mcdt_val_i   (mcdt_val),
      .mcdt_id_i    (mcdt_id),
      .fmt_req_o    (fmt_req_o),
      .fmt_grant_i  (fmt_grant),
      .fmt_chid_o   (fmt_chid_o),
      .fmt_length_o (fmt_length_o),
      .fmt_start_o  (fmt_start_o),
      .fmt_end_o    (fmt_end_o),
      .fmt_data_o   (fmt_data_o),
      .fmt_ovf_o    (fmt_ovf_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
      end
   endtask

   // Beat monitor: every data beat is matched against the per-channel queue.
   always @(negedge clk) begin
      if (!rstn) begin
         mon_idx = 0;
      end else if (fmt_start_o || mon_idx != 0) begin
         if (fmt_start_o) begin
            check("mon_start_pos", 64'(mon_idx), 64'd0);
            mon_idx = 0;
            pkt_order.push_back(fmt_chid_o);
         end
         mon_ch = int'(fmt_chid_o);
         if (mon_ch < 3 && exp_q[mon_ch].size() > 0) mon_exp = exp_q[mon_ch].pop_front();
         else mon_exp = 32'hDEAD_BEEF;
         check("mon_beat_data", 64'(fmt_data_o), 64'(mon_exp));
         check("mon_beat_end", 64'(fmt_end_o), 64'(mon_idx == PKT_LEN - 1));
         mon_idx = (mon_idx == PKT_LEN - 1) ? 0 : mon_idx + 1;
         beats_seen++;
      end else begin
         check("mon_idle_data", 64'(fmt_data_o), 64'd0);
      end
   end

   task automatic do_reset();
      rstn      = 1'b0;
      mcdt_val  = 1'b0;
      mcdt_id   = '0;
      mcdt_data = '0;
      fmt_grant = 1'b0;
      for (int c = 0; c < 3; c++) exp_q[c].delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic model_push(input logic [1:0] id, input logic [31:0] d);
      if (id != 2'd3 && exp_q[id].size() < DEPTH) exp_q[id].push_back(d);
   endtask

   task automatic push_word(input logic [1:0] id, input logic [31:0] d);
      mcdt_val  = 1'b1;
      mcdt_id   = id;
      mcdt_data = d;
      model_push(id, d);
      tick(1);
      mcdt_val = 1'b0;
   endtask

   task automatic wait_beats(input int target, input int bound, input string name);
      int n = 0;
      while (beats_seen < target && n < bound) begin
         tick(1);
         n++;
      end
      check(name, 64'(beats_seen), 64'(target));
   endtask

   task automatic wait_req(input int bound, input string name);
      int n = 0;
      while (!fmt_req_o && n < bound) begin
         tick(1);
         n++;
      end
      check(name, 64'(fmt_req_o), 64'd1);
   endtask

   initial begin
      int   base;
      int   base_o;
      bit   found;
      logic [63:0] act;

      // Single packet on channel 0 with grant tied high, cycle by cycle.
      //            val   id    data            gnt   req   chid  len   st    end   dout
      vecs[0]  = '{1'b1, 2'd0, 32'h00C0_0000, 1'b1, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 32'h0};
      vecs[1]  = '{1'b1, 2'd0, 32'h00C0_0001, 1'b1, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 32'h0};
      vecs[2]  = '{1'b1, 2'd0, 32'h00C0_0002, 1'b1, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 32'h0};
      vecs[3]  = '{1'b1, 2'd0, 32'h00C0_0003, 1'b1, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 32'h0};
      vecs[4]  = '{1'b0, 2'd0, 32'h0,         1'b1, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 32'h0};
      vecs[5]  = '{1'b0, 2'd0, 32'h0,         1'b1, 1'b1, 2'd0, 5'd4, 1'b0, 1'b0, 32'h0};
      vecs[6]  = '{1'b0, 2'd0, 32'h0,         1'b1, 1'b0, 2'd0, 5'd4, 1'b1, 1'b0, 32'h00C0_0000};
      vecs[7]  = '{1'b0, 2'd0, 32'h0,         1'b1, 1'b0, 2'd0, 5'd4, 1'b0, 1'b0, 32'h00C0_0001};
      vecs[8]  = '{1'b0, 2'd0, 32'h0,         1'b1, 1'b0, 2'd0, 5'd4, 1'b0, 1'b0, 32'h00C0_0002};
      vecs[9]  = '{1'b0, 2'd0, 32'h0,         1'b1, 1'b0, 2'd0, 5'd4, 1'b0, 1'b1, 32'h00C0_0003};
      vecs[10] = '{1'b0, 2'd0, 32'h0,         1'b1, 1'b0, 2'd0, 5'd4, 1'b0, 1'b0, 32'h0};
      vecs[11] = '{1'b0, 2'd0, 32'h0,         1'b1, 1'b0, 2'd0, 5'd4, 1'b0, 1'b0, 32'h0};

      repeat (2) @(posedge clk);
      #1;
      act = 64'({fmt_req_o, fmt_chid_o, fmt_length_o, fmt_start_o, fmt_end_o, fmt_data_o,
                 fmt_ovf_o});
      check("reset_outputs", act, 64'd0);

      do_reset();
      for (int i = 0; i < 12; i++) begin
         mcdt_val  = vecs[i].val;
         mcdt_id   = vecs[i].id;
         mcdt_data = vecs[i].data;
         fmt_grant = vecs[i].grant;
         if (vecs[i].val) model_push(vecs[i].id, vecs[i].data);
         @(negedge clk);
         act = 64'({fmt_req_o, fmt_chid_o, fmt_length_o, fmt_start_o, fmt_end_o, fmt_data_o,
                    fmt_ovf_o});
         check($sformatf("vec%0d", i), act,
               64'({vecs[i].req, vecs[i].chid, vecs[i].len, vecs[i].start, vecs[i].fin,
                    vecs[i].dout, 3'b000}));
         @(posedge clk);
         #1;
      end
      check("single_drained", 64'(exp_q[0].size()), 64'd0);

      // Round-robin: 8 words per channel preloaded under a withheld grant.
      do_reset();
      base   = beats_seen;
      base_o = pkt_order.size();
      for (int w = 0; w < 8; w++)
         for (int c = 0; c < 3; c++)
            push_word(2'(c), 32'hA000_0000 + 32'(c) * 32'h100 + 32'(w));
      fmt_grant = 1'b1;
      wait_beats(base + 24, 200, "rr_beats");
      for (int k = 0; k < 6; k++) begin
         act = (pkt_order.size() > base_o + k) ? 64'(pkt_order[base_o + k]) : 64'hF;
         check($sformatf("rr_order%0d", k), act, 64'(k % 3));
      end
      fmt_grant = 1'b0;

      // Grant stall on channel 2.
      do_reset();
      base = beats_seen;
      for (int w = 0; w < 4; w++) push_word(2'd2, 32'h5100_0000 + 32'(w));
      wait_req(10, "stall_req");
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("stall_hold", 64'({fmt_req_o, fmt_chid_o, fmt_start_o}), 64'({1'b1, 2'd2, 1'b0}));
         tick(1);
      end
      fmt_grant = 1'b1;
      @(negedge clk);
      check("stall_pre_grant", 64'({fmt_req_o, fmt_start_o}), 64'({1'b1, 1'b0}));
      tick(1);
      fmt_grant = 1'b0;
      @(negedge clk);
      check("stall_beat0", 64'({fmt_req_o, fmt_start_o, fmt_data_o}),
            64'({1'b0, 1'b1, 32'h5100_0000}));
      tick(1);
      wait_beats(base + 4, 20, "stall_beats");

      // Overflow: 17 words to channel 1 with no grant.
      do_reset();
      base = beats_seen;
      for (int w = 0; w < 16; w++) push_word(2'd1, 32'h0F00_0000 + 32'(w));
      check("ovf_clear_at_16", 64'(fmt_ovf_o), 64'd0);
      push_word(2'd1, 32'h0F00_0010);
      check("ovf_flag", 64'(fmt_ovf_o), 64'(3'b010));
      fmt_grant = 1'b1;
      wait_beats(base + 16, 120, "ovf_beats");
      tick(20);
      check("ovf_no_extra", 64'(beats_seen), 64'(base + 16));
      check("ovf_sticky", 64'(fmt_ovf_o), 64'(3'b010));
      fmt_grant = 1'b0;

      // Illegal id: words on id 3 must not reach any FIFO.
      do_reset();
      fmt_grant = 1'b1;
      base = beats_seen;
      for (int w = 0; w < 4; w++) push_word(2'd3, 32'h3300_0000 + 32'(w));
      for (int c = 0; c < 3; c++)
         for (int w = 0; w < 3; w++) push_word(2'(c), 32'h3400_0000 + 32'(c) * 32'h10 + 32'(w));
      tick(15);
      check("illegal_no_pkt", 64'(beats_seen), 64'(base));
      check("illegal_no_req", 64'(fmt_req_o), 64'd0);
      check("illegal_no_ovf", 64'(fmt_ovf_o), 64'd0);
      push_word(2'd1, 32'h3400_0013);
      wait_beats(base + 4, 20, "illegal_then_pkt");

      // Reset asserted during beat 2 of a packet.
      do_reset();
      fmt_grant = 1'b1;
      for (int w = 0; w < 4; w++) push_word(2'd0, 32'h7700_0000 + 32'(w));
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (fmt_start_o) found = 1'b1;
      end
      check("mrst_start_seen", 64'(found), 64'd1);
      tick(1);
      tick(1);
      check("mrst_beat2", 64'(fmt_data_o), 64'h7700_0002);
      rstn = 1'b0;
      #1;
      act = 64'({fmt_req_o, fmt_chid_o, fmt_length_o, fmt_start_o, fmt_end_o, fmt_data_o,
                 fmt_ovf_o});
      check("mrst_outputs_zero", act, 64'd0);
      do_reset();
      fmt_grant = 1'b1;
      base = beats_seen;
      for (int w = 0; w < 3; w++) push_word(2'd0, 32'h7800_0000 + 32'(w));
      tick(15);
      check("mrst_no_pkt", 64'(beats_seen), 64'(base));
      check("mrst_no_req", 64'(fmt_req_o), 64'd0);
      push_word(2'd0, 32'h7800_0003);
      wait_beats(base + 4, 20, "mrst_new_pkt");

      // Burst: 500 words per channel, interleaved, receiver always granting.
      do_reset();
      fmt_grant = 1'b1;
      base = beats_seen;
      for (int w = 0; w < 1500; w++) begin
         push_word(2'(w % 3), 32'hB000_0000 + 32'(w % 3) * 32'h0010_0000 + 32'(w));
         tick(1);
      end
      wait_beats(base + 1500, 1000, "burst_beats");
      check("burst_no_ovf", 64'(fmt_ovf_o), 64'd0);
      check("burst_drained", 64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 64'd0);
      fmt_grant = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
